// File: rtl/ext_io_pkg.sv
// Shared constants for the external-world I/O port controller: register map,
// port count and default widths.
package ext_io_pkg;

    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int NUM_PORTS           = 4;
    localparam int ADDR_W              = 3;

    localparam logic [ADDR_W-1:0] ADDR_PORT1    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_PORT2    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PORT3    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PORT4    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd5;

    // Data ports occupy the lower half of the map, so the MSB alone decodes them.
    function automatic logic is_port_addr(input logic [ADDR_W-1:0] addr);
        return (addr[ADDR_W-1] == 1'b0);
    endfunction

    function automatic logic [1:0] port_index(input logic [ADDR_W-1:0] addr);
        return addr[1:0];
    endfunction

endpackage

// File: rtl/ext_io_in_sync.sv
// One external input lane: a SYNC_STAGES-deep synchroniser followed by a
// previous-value register, producing a change flag while the two differ.
module ext_io_in_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] async_in,
    output logic [DATA_W-1:0] sync_out,
    output logic              change
);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_d;
    logic [DATA_W-1:0]                  prev_q;
    logic [DATA_W-1:0]                  prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // High for exactly one cycle per settled input change: prev catches up next edge.
    assign change = (sync_out != prev_q);

endmodule

// File: rtl/ext_io_port_ctrl.sv
// Processor-side responder for the four external-world ports: output latches,
// synchronised inputs, sticky change flags, interrupt mask and registered reads.
module ext_io_port_ctrl
    import ext_io_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic                 cpu_wr,
    input  logic                 cpu_rd,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_rvalid,
    input  logic [DATA_W-1:0]    InpExtWorld1,
    input  logic [DATA_W-1:0]    InpExtWorld2,
    input  logic [DATA_W-1:0]    InpExtWorld3,
    input  logic [DATA_W-1:0]    InpExtWorld4,
    output logic [DATA_W-1:0]    OutExtWorld1,
    output logic [DATA_W-1:0]    OutExtWorld2,
    output logic [DATA_W-1:0]    OutExtWorld3,
    output logic [DATA_W-1:0]    OutExtWorld4,
    output logic [NUM_PORTS-1:0] OutStrobe,
    output logic                 irq
);

    logic [DATA_W-1:0]    inp_w  [NUM_PORTS];
    logic [DATA_W-1:0]    sync_w [NUM_PORTS];
    logic [NUM_PORTS-1:0] change_w;

    logic [DATA_W-1:0]    out_q  [NUM_PORTS];
    logic [DATA_W-1:0]    out_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0] strobe_q, strobe_d;
    logic [NUM_PORTS-1:0] status_q, status_d;
    logic [NUM_PORTS-1:0] mask_q, mask_d;
    logic                 irq_q, irq_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;

    logic [NUM_PORTS-1:0] status_clr;
    logic [DATA_W-1:0]    rd_mux;
    logic [1:0]           port_idx;

    assign inp_w[0] = InpExtWorld1;
    assign inp_w[1] = InpExtWorld2;
    assign inp_w[2] = InpExtWorld3;
    assign inp_w[3] = InpExtWorld4;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        ext_io_in_sync #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_in_sync (
            .clk      (clk),
            .Reset    (Reset),
            .async_in (inp_w[p]),
            .sync_out (sync_w[p]),
            .change   (change_w[p])
        );
    end

    assign port_idx = port_index(cpu_addr);

    always_comb begin
        rd_mux = '0;
        case (cpu_addr)
            ADDR_PORT1, ADDR_PORT2,
            ADDR_PORT3, ADDR_PORT4: rd_mux = sync_w[port_idx];
            ADDR_STATUS:            rd_mux = {{(DATA_W-NUM_PORTS){1'b0}}, status_q};
            ADDR_IRQ_MASK:          rd_mux = {{(DATA_W-NUM_PORTS){1'b0}}, mask_q};
            default:                rd_mux = '0;
        endcase
    end

    // Reads sample pre-edge state, so a same-cycle write never leaks into rdata.
    always_comb begin
        out_d      = out_q;
        strobe_d   = '0;
        mask_d     = mask_q;
        status_clr = '0;
        rdata_d    = rdata_q;
        rvalid_d   = cpu_rd;
        irq_d      = |(status_q & mask_q);

        if (cpu_wr) begin
            if (is_port_addr(cpu_addr)) begin
                out_d[port_idx]    = cpu_wdata;
                strobe_d[port_idx] = 1'b1;
            end else if (cpu_addr == ADDR_STATUS) begin
                status_clr = cpu_wdata[NUM_PORTS-1:0];
            end else if (cpu_addr == ADDR_IRQ_MASK) begin
                mask_d = cpu_wdata[NUM_PORTS-1:0];
            end
        end

        if (cpu_rd) begin
            rdata_d = rd_mux;
            if (is_port_addr(cpu_addr)) begin
                status_clr[port_idx] = 1'b1;
            end
        end

        // A new change outranks any clear landing on the same edge.
        status_d = (status_q & ~status_clr) | change_w;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            out_q    <= '{default: '0};
            strobe_q <= '0;
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            strobe_q <= strobe_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign OutExtWorld1 = out_q[0];
    assign OutExtWorld2 = out_q[1];
    assign OutExtWorld3 = out_q[2];
    assign OutExtWorld4 = out_q[3];
    assign OutStrobe    = strobe_q;
    assign irq          = irq_q;
    assign cpu_rdata    = rdata_q;
    assign cpu_rvalid   = rvalid_q;

endmodule

// File: tb/tb_ext_io_port_ctrl.sv
// Bench for ext_io_port_ctrl: directed scenarios with fixed expectations, then
// randomised traffic checked cycle by cycle against a pin-history reference model.
module tb_ext_io_port_ctrl;

    localparam int S = 2;

    logic       clk;
    logic       Reset;
    logic [2:0] cpu_addr;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_rvalid;
    logic [7:0] inp  [4];
    logic [7:0] outp [4];
    logic [3:0] OutStrobe;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    ext_io_port_ctrl dut (
        .clk          (clk),
        .Reset        (Reset),
        .cpu_addr     (cpu_addr),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .InpExtWorld1 (inp[0]),
        .InpExtWorld2 (inp[1]),
        .InpExtWorld3 (inp[2]),
        .InpExtWorld4 (inp[3]),
        .OutExtWorld1 (outp[0]),
        .OutExtWorld2 (outp[1]),
        .OutExtWorld3 (outp[2]),
        .OutExtWorld4 (outp[3]),
        .OutStrobe    (OutStrobe),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pin is seen by the processor S edges after it is sampled,
    // and a flag sets on the edge after the seen value differs from the one before.
    logic [7:0] hist [4][S+1];
    logic [7:0] m_out [4];
    logic [3:0] m_strobe, m_status, m_mask;
    logic       m_irq, m_rvalid;
    logic [7:0] m_rdata;

    function automatic logic [3:0] f_sets();
        logic [3:0] s = '0;
        for (int p = 0; p < 4; p++) s[p] = (hist[p][S-1] != hist[p][S]);
        return s;
    endfunction

    function automatic logic [3:0] f_clears();
        logic [3:0] c = '0;
        if (cpu_rd && cpu_addr < 3'd4) c[cpu_addr[1:0]] = 1'b1;
        if (cpu_wr && cpu_addr == 3'd4) c = c | cpu_wdata[3:0];
        return c;
    endfunction

    function automatic logic [7:0] f_read();
        if (cpu_addr < 3'd4) return hist[cpu_addr[1:0]][S-1];
        if (cpu_addr == 3'd4) return {4'h0, m_status};
        if (cpu_addr == 3'd5) return {4'h0, m_mask};
        return 8'h00;
    endfunction

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int p = 0; p < 4; p++) begin
                m_out[p] <= 8'h00;
                for (int k = 0; k <= S; k++) hist[p][k] <= 8'h00;
            end
            m_strobe <= 4'h0;
            m_status <= 4'h0;
            m_mask   <= 4'h0;
            m_irq    <= 1'b0;
            m_rvalid <= 1'b0;
            m_rdata  <= 8'h00;
        end else begin
            for (int p = 0; p < 4; p++) begin
                hist[p][0] <= inp[p];
                for (int k = 1; k <= S; k++) hist[p][k] <= hist[p][k-1];
            end
            m_irq    <= |(m_status & m_mask);
            m_status <= (m_status & ~f_clears()) | f_sets();
            m_rvalid <= cpu_rd;
            if (cpu_rd) m_rdata <= f_read();
            m_strobe <= 4'h0;
            if (cpu_wr && cpu_addr < 3'd4) begin
                m_out[cpu_addr[1:0]]    <= cpu_wdata;
                m_strobe[cpu_addr[1:0]] <= 1'b1;
            end
            if (cpu_wr && cpu_addr == 3'd5) m_mask <= cpu_wdata[3:0];
        end
    end

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (outp[0] !== 8'h00 || OutStrobe !== 4'h0 || cpu_rvalid !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: out1=%h strobe=%b rvalid=%b irq=%b, required all 0", outp[0], OutStrobe, cpu_rvalid, irq);
        end
        cpu_wr = 1'b1; cpu_addr = 3'd0; cpu_wdata = 8'hAA;
        @(negedge clk);
        n_checks++;
        if (outp[0] !== 8'hAA) begin
            n_fail++;
            $display("[TB] FAIL reset_pre_out1: got %h required aa", outp[0]);
        end
        cpu_addr = 3'd5; cpu_wdata = 8'h05;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 3'd5;
        @(posedge clk);
        #2;
        Reset = 1'b1;
        #1;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (outp[p] !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL reset_async_out%0d: got %h required 00", p + 1, outp[p]);
            end
        end
        n_checks++;
        if (OutStrobe !== 4'h0 || cpu_rdata !== 8'h00 || cpu_rvalid !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_async_ctl: strobe=%b rdata=%h rvalid=%b irq=%b, required all 0", OutStrobe, cpu_rdata, cpu_rvalid, irq);
        end
        @(negedge clk);
        Reset = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_discard_rvalid: got %b required 0", cpu_rvalid);
        end
        cpu_rd = 1'b1; cpu_addr = 3'd5;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_mask: rvalid=%b rdata=%h required 1/00", cpu_rvalid, cpu_rdata);
        end
        cpu_addr = 3'd4;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_status: rvalid=%b rdata=%h required 1/00", cpu_rvalid, cpu_rdata);
        end
        cpu_rd = 1'b0;
    endtask

    task automatic test_output_write();
        @(negedge clk);
        cpu_wr = 1'b1; cpu_addr = 3'd2; cpu_wdata = 8'h3C;
        @(negedge clk);
        cpu_wr = 1'b0;
        n_checks++;
        if (outp[2] !== 8'h3C || OutStrobe !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL out_write: out3=%h strobe=%b required 3c/0100", outp[2], OutStrobe);
        end
        n_checks++;
        if (outp[0] !== 8'h00 || outp[1] !== 8'h00 || outp[3] !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL out_others: %h %h %h required 00 00 00", outp[0], outp[1], outp[3]);
        end
        @(negedge clk);
        n_checks++;
        if (outp[2] !== 8'h3C || OutStrobe !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL out_strobe_once: out3=%h strobe=%b required 3c/0000", outp[2], OutStrobe);
        end
    endtask

    task automatic test_input_change();
        @(negedge clk);
        inp[0] = 8'hAA; cpu_rd = 1'b1; cpu_addr = 3'd4;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_rvalid !== 1'b1 || cpu_rdata !== ((k == 4) ? 8'h01 : 8'h00)) begin
                n_fail++;
                $display("[TB] FAIL chg_status_t%0d: rvalid=%b rdata=%h required 1/%h", k, cpu_rvalid, cpu_rdata, (k == 4) ? 8'h01 : 8'h00);
            end
        end
        cpu_addr = 3'd0;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hAA) begin
            n_fail++;
            $display("[TB] FAIL chg_read_port1: rvalid=%b rdata=%h required 1/aa", cpu_rvalid, cpu_rdata);
        end
        cpu_addr = 3'd4;
        @(negedge clk);
        n_checks++;
        if (cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL chg_read_clear: status=%h required 00", cpu_rdata);
        end
        cpu_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL chg_rdata_hold: rvalid=%b rdata=%h required 0/00", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_irq_mask();
        @(negedge clk);
        cpu_wr = 1'b1; cpu_addr = 3'd5; cpu_wdata = 8'h02;
        @(negedge clk);
        cpu_wr = 1'b0; inp[1] = 8'hCC;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (irq !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL irq_early_t%0d: got %b required 0", k, irq);
            end
        end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_rise: got %b required 1", irq);
        end
        inp[3] = 8'h55;
        for (int k = 6; k <= 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (irq !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL irq_masked_port4_t%0d: got %b required 1", k, irq);
            end
        end
        cpu_wr = 1'b1; cpu_addr = 3'd4; cpu_wdata = 8'h02;
        @(negedge clk);
        cpu_wr = 1'b0;
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_w1c_lag: got %b required 1", irq);
        end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_w1c_drop: got %b required 0", irq);
        end
        cpu_rd = 1'b1; cpu_addr = 3'd4;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h08) begin
            n_fail++;
            $display("[TB] FAIL irq_status_pending: rvalid=%b rdata=%h required 1/08", cpu_rvalid, cpu_rdata);
        end
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 3'd5; cpu_wdata = 8'h0A;
        @(negedge clk);
        cpu_wr = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_unmask_lag: got %b required 0", irq);
        end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_unmask_rise: got %b required 1", irq);
        end
        cpu_wr = 1'b1; cpu_addr = 3'd4; cpu_wdata = 8'h08;
        @(negedge clk);
        cpu_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_clear_port4: got %b required 0", irq);
        end
        cpu_wr = 1'b1; cpu_addr = 3'd5; cpu_wdata = 8'h02;
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic test_collision();
        @(negedge clk);
        inp[2] = 8'hF0;
        repeat (4) @(negedge clk);
        inp[2] = 8'h0F;
        @(negedge clk);
        @(negedge clk);
        cpu_wr = 1'b1; cpu_addr = 3'd4; cpu_wdata = 8'h04;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 3'd4;
        @(negedge clk);
        n_checks++;
        if (cpu_rdata !== 8'h04) begin
            n_fail++;
            $display("[TB] FAIL collide_set_wins: status=%h required 04", cpu_rdata);
        end
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 3'd4; cpu_wdata = 8'h04;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 3'd4;
        @(negedge clk);
        n_checks++;
        if (cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL collide_w1c_after: status=%h required 00", cpu_rdata);
        end
        cpu_rd = 1'b0;
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_addr = 3'd5; cpu_wdata = 8'hFD;
        @(negedge clk);
        cpu_wr = 1'b0;
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h02) begin
            n_fail++;
            $display("[TB] FAIL simul_old_mask: rvalid=%b rdata=%h required 1/02", cpu_rvalid, cpu_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (cpu_rdata !== 8'h0D) begin
            n_fail++;
            $display("[TB] FAIL simul_new_mask: rdata=%h required 0d", cpu_rdata);
        end
        cpu_addr = 3'd7;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL unused_read7: rvalid=%b rdata=%h required 1/00", cpu_rvalid, cpu_rdata);
        end
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 3'd6; cpu_wdata = 8'hFF;
        @(negedge clk);
        cpu_wr = 1'b0;
        n_checks++;
        if (OutStrobe !== 4'h0 || outp[0] !== 8'h00 || outp[1] !== 8'h00 || outp[2] !== 8'h3C || outp[3] !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL unused_write6_out: strobe=%b outs=%h %h %h %h required 0000 00 00 3c 00", OutStrobe, outp[0], outp[1], outp[2], outp[3]);
        end
        cpu_rd = 1'b1; cpu_addr = 3'd5;
        @(negedge clk);
        n_checks++;
        if (cpu_rdata !== 8'h0D) begin
            n_fail++;
            $display("[TB] FAIL unused_write6_mask: rdata=%h required 0d", cpu_rdata);
        end
        cpu_addr = 3'd4;
        @(negedge clk);
        n_checks++;
        if (cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL unused_write6_status: rdata=%h required 00", cpu_rdata);
        end
        cpu_rd = 1'b0;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                n_checks++;
                if (outp[p] !== m_out[p]) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_out%0d cyc %0d: got %h required %h", p + 1, cyc, outp[p], m_out[p]);
                end
            end
            n_checks++;
            if (OutStrobe !== m_strobe) begin
                n_fail++;
                $display("[TB] FAIL rnd_strobe cyc %0d: got %b required %b", cyc, OutStrobe, m_strobe);
            end
            n_checks++;
            if (cpu_rvalid !== m_rvalid || cpu_rdata !== m_rdata) begin
                n_fail++;
                $display("[TB] FAIL rnd_read cyc %0d: rvalid=%b rdata=%h required %b/%h", cyc, cpu_rvalid, cpu_rdata, m_rvalid, m_rdata);
            end
            n_checks++;
            if (irq !== m_irq) begin
                n_fail++;
                $display("[TB] FAIL rnd_irq cyc %0d: got %b required %b", cyc, irq, m_irq);
            end
            cpu_wr    = ($urandom_range(0, 2) == 0);
            cpu_rd    = ($urandom_range(0, 2) == 0);
            cpu_addr  = 3'($urandom_range(0, 7));
            cpu_wdata = 8'($urandom);
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 5) == 0) inp[p] = 8'($urandom);
            end
        end
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    initial begin
        Reset     = 1'b0;
        cpu_addr  = 3'd0;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wdata = 8'h00;
        for (int p = 0; p < 4; p++) inp[p] = 8'h00;
        #2 Reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;

        test_reset();
        test_output_write();
        test_input_change();
        test_irq_mask();
        test_collision();
        test_simultaneous();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
